// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bundle: execution-unit result requests, redirect,
// per-source availability and the broadcast bus.
interface cdb_arbiter_if #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2
);
  logic             redirect;

  logic             aluDataBusReq;
  logic [WIDTH:0]   aluResult;
  logic [ROB:0]     ALURob;
  logic             aluAvailable;

  logic             branchDataBusReq;
  logic [WIDTH:0]   branchResult;
  logic [ROB:0]     branchRob;
  logic             branchAvailable;

  logic             validBroadcast;
  logic [WIDTH:0]   valueBroadcast;
  logic [ROB:0]     robBroadcast;

  // Arbiter side
  modport slave (
    input  redirect,
    input  aluDataBusReq, aluResult, ALURob,
    input  branchDataBusReq, branchResult, branchRob,
    output aluAvailable, branchAvailable,
    output validBroadcast, valueBroadcast, robBroadcast
  );

  // Producer / consumer side
  modport master (
    output redirect,
    output aluDataBusReq, aluResult, ALURob,
    output branchDataBusReq, branchResult, branchRob,
    input  aluAvailable, branchAvailable,
    input  validBroadcast, valueBroadcast, robBroadcast
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs, round-robin grant, registered broadcast.
// Optional CDB_STATS_EN adds a saturating 16-bit contention counter (conflictCount).
module cdb_arbiter #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]   conflictCount
`endif
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned RW = ROB + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [DW-1:0] value;
    logic [RW-1:0] rob;
  } entry_t;

  typedef enum logic {
    SRC_ALU    = 1'b0,
    SRC_BRANCH = 1'b1
  } src_e;

  entry_t        alu_mem_q [DEPTH];
  entry_t        br_mem_q  [DEPTH];

  logic [CW-1:0] alu_cnt_q, alu_cnt_d, br_cnt_q, br_cnt_d;
  logic [PW-1:0] alu_rd_q, alu_rd_d, alu_wr_q, alu_wr_d;
  logic [PW-1:0] br_rd_q, br_rd_d, br_wr_q, br_wr_d;
  logic          alu_avail_q, alu_avail_d, br_avail_q, br_avail_d;
  src_e          last_q, last_d;
  logic          valid_q, valid_d;
  entry_t        bcast_q, bcast_d;

  logic          alu_ne_c, br_ne_c;
  logic          alu_push_c, br_push_c, alu_pop_c, br_pop_c;

  // Grant, push/pop and next-state; redirect overrides everything except lastGrant
  always_comb begin
    alu_cnt_d   = alu_cnt_q;
    br_cnt_d    = br_cnt_q;
    alu_rd_d    = alu_rd_q;
    alu_wr_d    = alu_wr_q;
    br_rd_d     = br_rd_q;
    br_wr_d     = br_wr_q;
    alu_avail_d = alu_avail_q;
    br_avail_d  = br_avail_q;
    last_d      = last_q;
    valid_d     = 1'b0;
    bcast_d     = bcast_q;

    alu_ne_c    = (alu_cnt_q != '0);
    br_ne_c     = (br_cnt_q != '0);
    alu_push_c  = bus.aluDataBusReq && alu_avail_q && !bus.redirect;
    br_push_c   = bus.branchDataBusReq && br_avail_q && !bus.redirect;
    alu_pop_c   = !bus.redirect && alu_ne_c && (!br_ne_c || (last_q == SRC_BRANCH));
    br_pop_c    = !bus.redirect && br_ne_c && (!alu_ne_c || (last_q == SRC_ALU));

    if (bus.redirect) begin
      alu_cnt_d   = '0;
      br_cnt_d    = '0;
      alu_rd_d    = '0;
      alu_wr_d    = '0;
      br_rd_d     = '0;
      br_wr_d     = '0;
      alu_avail_d = 1'b1;
      br_avail_d  = 1'b1;
    end else begin
      if (alu_push_c) alu_wr_d = alu_wr_q + PW'(1);
      if (alu_pop_c)  alu_rd_d = alu_rd_q + PW'(1);
      if (br_push_c)  br_wr_d  = br_wr_q + PW'(1);
      if (br_pop_c)   br_rd_d  = br_rd_q + PW'(1);

      alu_cnt_d   = alu_cnt_q + CW'(alu_push_c) - CW'(alu_pop_c);
      br_cnt_d    = br_cnt_q + CW'(br_push_c) - CW'(br_pop_c);
      alu_avail_d = (alu_cnt_d < CW'(DEPTH));
      br_avail_d  = (br_cnt_d < CW'(DEPTH));

      if (alu_pop_c) begin
        valid_d = 1'b1;
        bcast_d = alu_mem_q[alu_rd_q];
        last_d  = SRC_ALU;
      end else if (br_pop_c) begin
        valid_d = 1'b1;
        bcast_d = br_mem_q[br_rd_q];
        last_d  = SRC_BRANCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_cnt_q   <= '0;
      br_cnt_q    <= '0;
      alu_rd_q    <= '0;
      alu_wr_q    <= '0;
      br_rd_q     <= '0;
      br_wr_q     <= '0;
      alu_avail_q <= 1'b1;
      br_avail_q  <= 1'b1;
      last_q      <= SRC_BRANCH;
      valid_q     <= 1'b0;
      bcast_q     <= '0;
    end else begin
      alu_cnt_q   <= alu_cnt_d;
      br_cnt_q    <= br_cnt_d;
      alu_rd_q    <= alu_rd_d;
      alu_wr_q    <= alu_wr_d;
      br_rd_q     <= br_rd_d;
      br_wr_q     <= br_wr_d;
      alu_avail_q <= alu_avail_d;
      br_avail_q  <= br_avail_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      bcast_q     <= bcast_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counts
  always_ff @(posedge clk) begin
    if (alu_push_c) alu_mem_q[alu_wr_q] <= entry_t'{value: bus.aluResult, rob: bus.ALURob};
    if (br_push_c)  br_mem_q[br_wr_q]   <= entry_t'{value: bus.branchResult, rob: bus.branchRob};
  end

  assign bus.aluAvailable    = alu_avail_q;
  assign bus.branchAvailable = br_avail_q;
  assign bus.validBroadcast  = valid_q;
  assign bus.valueBroadcast  = bcast_q.value;
  assign bus.robBroadcast    = bcast_q.rob;

`ifdef CDB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Counts contention edges regardless of redirect; only reset clears it
  always_comb begin
    conflict_d = conflict_q;
    if (alu_ne_c && br_ne_c && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign conflictCount = conflict_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the execution units and the broadcast consumers (reorder buffer, reservation stations, register status) of the out-of-order core. It buffers completed results from the ALU and the branch unit in per-source FIFOs. Each cycle it grants one buffered result round-robin and drives it onto the registered broadcast bus (`validBroadcast`/`valueBroadcast`/`robBroadcast`). On a branch redirect it discards every buffered, speculative result.

## Interface
- `WIDTH`, 31, MSB index of result data.
- `ROB`, 2, MSB index of ROB tag.
- `DEPTH`, 2, entries per source FIFO; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  squash; flushes both FIFOs and the broadcast register.
- `aluDataBusReq`  in  1  ALU result valid.
- `aluResult`  in  WIDTH+1  ALU result value.
- `ALURob`  in  ROB+1  ALU result ROB tag.
- `aluAvailable`  out  1  ALU FIFO can accept.
- `branchDataBusReq`  in  1  branch result valid.
- `branchResult`  in  WIDTH+1  branch result value (link address).
- `branchRob`  in  ROB+1  branch result ROB tag.
- `branchAvailable`  out  1  branch FIFO can accept.
- `validBroadcast`  out  1  broadcast valid, one cycle per result.
- `valueBroadcast`  out  WIDTH+1  broadcast value.
- `robBroadcast`  out  ROB+1  broadcast ROB tag.

## Operation
- Push: at a rising edge where `xDataBusReq && xAvailable`, the {result, tag} pair is written to the tail of that source's FIFO. A request while unavailable is ignored. The source must hold the request.
- `xAvailable` = FIFO count < `DEPTH`. It comes from registered count only: a pop in the same cycle does not raise it.
- Arbitration is combinational on the FIFO heads at the start of the cycle.
  - One non-empty FIFO: it wins.
  - Both non-empty: the source not granted last wins.
  - Neither non-empty: no grant.
- `lastGrant` updates to the winner on every grant and holds when there is no grant.
- At the edge, the winner's head is popped into the broadcast registers and `validBroadcast` is set to 1. With no grant, `validBroadcast` is set to 0. `valueBroadcast` and `robBroadcast` hold their last values.
- Push and pop on the same FIFO at the same edge are legal when count < `DEPTH`; the count is unchanged.
- Count width is clog2(`DEPTH`)+1. Read and write pointers wrap modulo `DEPTH`.
- Redirect (synchronous) takes priority over push and pop. At that edge:
  - both counts and pointers go to 0;
  - `validBroadcast` goes to 0;
  - pushes presented in that cycle are dropped;
  - `lastGrant` is unchanged.
- Reset (asynchronous, any time, including mid-burst):
  - FIFOs empty; `validBroadcast`, `valueBroadcast`, `robBroadcast` = 0;
  - `aluAvailable` = `branchAvailable` = 1;
  - `lastGrant` = branch, so the ALU wins the first contention.

## Timing
- Latency is two edges, push to broadcast. A result pushed at edge E0 is granted at E1 at the earliest and is visible on the broadcast bus during the cycle after E1.
- Throughput is one broadcast per cycle in total.
- Under continuous contention each source gets every other cycle.
- `validBroadcast` is asserted for exactly one cycle per result. Back-to-back results assert it on consecutive cycles.
- All outputs are registered or derived from registered state only. There is no input-to-output combinational path.

## Configuration
- `CDB_STATS_EN` defined:
  - Adds output `conflictCount` (16 bits).
  - It increments at each edge where both FIFOs are non-empty and saturates at 16'hFFFF.
  - It is cleared by `reset` only; `redirect` does not clear it.
- `CDB_STATS_EN` undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset, then release: all broadcast outputs 0, both available flags 1, no `validBroadcast` for 10 idle cycles.
- ALU push `aluResult`=32'h0000_00AA, `ALURob`=3 at E0 -> during cycle after E1: `validBroadcast`=1, `valueBroadcast`=32'hAA, `robBroadcast`=3. Next cycle `validBroadcast`=0.
- ALU push {32'h11, rob 1} and branch push {32'h22, rob 2} at the same edge after reset -> broadcast of 32'h11/rob 1, then 32'h22/rob 2 on the next cycle.
- Both sources push every cycle when available (`DEPTH`=2):
  - broadcasts alternate ALU/branch starting with ALU;
  - `aluAvailable` and `branchAvailable` each deassert within 4 cycles;
  - no result is lost or duplicated, and ROB tags are in push order per source.
- Two ALU results buffered, `redirect`=1 for one edge together with a new branch push -> next cycle `validBroadcast`=0 and both available flags 1. No broadcast of any of the three results ever appears.
- With `CDB_STATS_EN`:
  - hold both FIFOs non-empty for 5 edges -> `conflictCount`=5;
  - then pulse `redirect` -> still 5;
  - assert `reset` mid-cycle -> 0 immediately.
